// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered issue queue in front of the ALU. Entries wait for operand
// wakeup from the result bus; the oldest ready entry is issued into registered outputs.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int TAGW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [11:0]        disp_alusignals,
    input  logic [15:0]        disp_instr,
    input  logic [4:0]         disp_immx,
    input  logic               disp_isimmediate,
    input  logic [DW-1:0]      disp_op1,
    input  logic [DW-1:0]      disp_op2,
    input  logic               disp_op1_rdy,
    input  logic               disp_op2_rdy,
    input  logic [TAGW-1:0]    disp_op1_tag,
    input  logic [TAGW-1:0]    disp_op2_tag,
    input  logic               wb_valid,
    input  logic [TAGW+DW-1:0] wb_rdval,
    output logic               iss_valid,
    output logic [11:0]        alusignals,
    output logic [DW-1:0]      op1,
    output logic [DW-1:0]      op2,
    output logic [4:0]         immx,
    output logic [15:0]        instr,
    output logic               isimmediate,
    output logic [3:0]         count
);
    localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [11:0]     alu;
        logic [15:0]     instr;
        logic [4:0]      immx;
        logic            isimm;
        logic [DW-1:0]   op1;
        logic            op1_rdy;
        logic [TAGW-1:0] op1_tag;
        logic [DW-1:0]   op2;
        logic            op2_rdy;
        logic [TAGW-1:0] op2_tag;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q, ent_d, woke;
    entry_t             new_ent;
    logic [3:0]         count_q, count_d, wr_idx;
    logic [DEPTH-1:0]   vld, elig;
    logic [SELW-1:0]    sel;
    logic               acc, iss;
    logic [TAGW-1:0]    wb_tag;
    logic [DW-1:0]      wb_val;

    logic               iss_valid_q, iss_valid_d, isimm_q, isimm_d;
    logic [11:0]        alu_q, alu_d;
    logic [DW-1:0]      op1_q, op1_d, op2_q, op2_d;
    logic [4:0]         immx_q, immx_d;
    logic [15:0]        instr_q, instr_d;

    assign wb_tag     = wb_rdval[TAGW+DW-1:DW];
    assign wb_val     = wb_rdval[DW-1:0];
    assign disp_ready = (count_q < 4'(DEPTH));
    assign acc        = disp_valid & disp_ready;

    // Eligibility uses pre-wakeup state, so a woken entry issues one cycle later.
    for (genvar g = 0; g < DEPTH; g++) begin : g_elig
        assign vld[g]  = (count_q > 4'(g));
        assign elig[g] = vld[g] & ent_q[g].op1_rdy & (ent_q[g].op2_rdy | ent_q[g].isimm);
    end

    always_comb begin
        woke = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && vld[i]) begin
                if (!woke[i].op1_rdy && woke[i].op1_tag == wb_tag) begin
                    woke[i].op1     = wb_val;
                    woke[i].op1_rdy = 1'b1;
                end
                if (!woke[i].op2_rdy && woke[i].op2_tag == wb_tag) begin
                    woke[i].op2     = wb_val;
                    woke[i].op2_rdy = 1'b1;
                end
            end
        end

        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (elig[i]) sel = SELW'(i);
        iss = |elig;

        new_ent         = '0;
        new_ent.alu     = disp_alusignals;
        new_ent.instr   = disp_instr;
        new_ent.immx    = disp_immx;
        new_ent.isimm   = disp_isimmediate;
        new_ent.op1     = disp_op1;
        new_ent.op1_rdy = disp_op1_rdy;
        new_ent.op1_tag = disp_op1_tag;
        new_ent.op2     = disp_op2;
        new_ent.op2_rdy = disp_op2_rdy | disp_isimmediate;
        new_ent.op2_tag = disp_op2_tag;
        if (wb_valid && !new_ent.op1_rdy && new_ent.op1_tag == wb_tag) begin
            new_ent.op1     = wb_val;
            new_ent.op1_rdy = 1'b1;
        end
        if (wb_valid && !new_ent.op2_rdy && new_ent.op2_tag == wb_tag) begin
            new_ent.op2     = wb_val;
            new_ent.op2_rdy = 1'b1;
        end

        // Entries above the issued slot slide down; the new entry lands after compaction.
        for (int i = 0; i < DEPTH - 1; i++)
            ent_d[i] = (iss && SELW'(i) >= sel) ? woke[i+1] : woke[i];
        ent_d[DEPTH-1] = iss ? '0 : woke[DEPTH-1];
        wr_idx = count_q - {3'b0, iss};
        if (acc) ent_d[wr_idx[SELW-1:0]] = new_ent;
        count_d = count_q + {3'b0, acc} - {3'b0, iss};

        iss_valid_d = iss;
        alu_d       = iss ? ent_q[sel].alu   : alu_q;
        op1_d       = iss ? ent_q[sel].op1   : op1_q;
        op2_d       = iss ? ent_q[sel].op2   : op2_q;
        immx_d      = iss ? ent_q[sel].immx  : immx_q;
        instr_d     = iss ? ent_q[sel].instr : instr_q;
        isimm_d     = iss ? ent_q[sel].isimm : isimm_q;

        if (flush) begin
            ent_d       = '0;
            count_d     = '0;
            iss_valid_d = 1'b0;
            alu_d       = '0;
            op1_d       = '0;
            op2_d       = '0;
            immx_d      = '0;
            instr_d     = '0;
            isimm_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q       <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            alu_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            immx_q      <= '0;
            instr_q     <= '0;
            isimm_q     <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            alu_q       <= alu_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            immx_q      <= immx_d;
            instr_q     <= instr_d;
            isimm_q     <= isimm_d;
        end
    end

    assign iss_valid   = iss_valid_q;
    assign alusignals  = alu_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign immx        = immx_q;
    assign instr       = instr_q;
    assign isimmediate = isimm_q;
    assign count       = count_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus randomized traffic compared
// against a queue-based reference model.
module tb_alu_issue_queue;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        disp_valid = 1'b0, disp_ready;
    logic [11:0] disp_alusignals = '0;
    logic [15:0] disp_instr = '0;
    logic [4:0]  disp_immx = '0;
    logic        disp_isimmediate = 1'b0;
    logic [15:0] disp_op1 = '0, disp_op2 = '0;
    logic        disp_op1_rdy = 1'b0, disp_op2_rdy = 1'b0;
    logic [2:0]  disp_op1_tag = '0, disp_op2_tag = '0;
    logic        wb_valid = 1'b0;
    logic [18:0] wb_rdval = '0;
    logic        iss_valid, isimmediate;
    logic [11:0] alusignals;
    logic [15:0] op1, op2, instr;
    logic [4:0]  immx;
    logic [3:0]  count;

    int n_chk = 0, n_pass = 0;

    alu_issue_queue #(.DEPTH(4), .DW(16), .TAGW(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_alusignals(disp_alusignals), .disp_instr(disp_instr), .disp_immx(disp_immx),
        .disp_isimmediate(disp_isimmediate), .disp_op1(disp_op1), .disp_op2(disp_op2),
        .disp_op1_rdy(disp_op1_rdy), .disp_op2_rdy(disp_op2_rdy),
        .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag),
        .wb_valid(wb_valid), .wb_rdval(wb_rdval),
        .iss_valid(iss_valid), .alusignals(alusignals), .op1(op1), .op2(op2),
        .immx(immx), .instr(instr), .isimmediate(isimmediate), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] alu;
        logic [15:0] instr;
        logic [4:0]  immx;
        logic        isimm;
        logic [15:0] op1, op2;
        logic        r1, r2;
        logic [2:0]  t1, t2;
    } ment_t;

    ment_t       mq[$];
    logic        e_iss = 1'b0, e_isimm = 1'b0;
    logic [11:0] e_alu = '0;
    logic [15:0] e_op1 = '0, e_op2 = '0, e_instr = '0;
    logic [4:0]  e_immx = '0;

    // Reference: oldest operand-complete op leaves; results wake waiting operands;
    // new op joins the tail, grabbing a same-cycle result if it was waiting for it.
    task automatic model_step();
        ment_t n;
        int    e = -1;
        bit    acc = disp_valid && (mq.size() < 4);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && (mq[i].r2 || mq[i].isimm)) begin e = i; break; end
        if (flush) begin
            mq.delete();
            e_iss = 0; e_alu = '0; e_op1 = '0; e_op2 = '0; e_immx = '0; e_instr = '0; e_isimm = 0;
            return;
        end
        e_iss = (e >= 0);
        if (e >= 0) begin
            e_alu = mq[e].alu; e_op1 = mq[e].op1; e_op2 = mq[e].op2;
            e_immx = mq[e].immx; e_instr = mq[e].instr; e_isimm = mq[e].isimm;
        end
        if (wb_valid)
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].r1 && mq[i].t1 == wb_rdval[18:16]) begin mq[i].op1 = wb_rdval[15:0]; mq[i].r1 = 1; end
                if (!mq[i].r2 && !mq[i].isimm && mq[i].t2 == wb_rdval[18:16]) begin mq[i].op2 = wb_rdval[15:0]; mq[i].r2 = 1; end
            end
        if (e >= 0) mq.delete(e);
        if (acc) begin
            n.alu = disp_alusignals; n.instr = disp_instr; n.immx = disp_immx; n.isimm = disp_isimmediate;
            n.op1 = disp_op1; n.r1 = disp_op1_rdy; n.t1 = disp_op1_tag;
            n.op2 = disp_op2; n.r2 = disp_op2_rdy; n.t2 = disp_op2_tag;
            if (wb_valid && !n.r1 && n.t1 == wb_rdval[18:16]) begin n.op1 = wb_rdval[15:0]; n.r1 = 1; end
            if (wb_valid && !n.r2 && !n.isimm && n.t2 == wb_rdval[18:16]) begin n.op2 = wb_rdval[15:0]; n.r2 = 1; end
            mq.push_back(n);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_iss = 0; e_alu = '0; e_op1 = '0; e_op2 = '0; e_immx = '0; e_instr = '0; e_isimm = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; wb_valid = 0; flush = 0;
    endtask

    task automatic set_disp(input logic [11:0] a, input logic [15:0] ins, input logic [4:0] im,
                            input logic isim, input logic [15:0] o1, input logic r1, input logic [2:0] t1,
                            input logic [15:0] o2, input logic r2, input logic [2:0] t2);
        disp_valid = 1; disp_alusignals = a; disp_instr = ins; disp_immx = im; disp_isimmediate = isim;
        disp_op1 = o1; disp_op1_rdy = r1; disp_op1_tag = t1;
        disp_op2 = o2; disp_op2_rdy = r2; disp_op2_tag = t2;
    endtask

    task automatic set_wb(input logic [2:0] t, input logic [15:0] v);
        wb_valid = 1; wb_rdval = {t, v};
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        #3;
        n_chk++; if (count !== 4'd0) $display("FAIL reset_count got %0h want 0", count); else n_pass++;
        n_chk++; if (iss_valid !== 1'b0) $display("FAIL reset_iss got %0b want 0", iss_valid); else n_pass++;
        n_chk++; if (disp_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", disp_ready); else n_pass++;
        n_chk++; if ({alusignals, op1, op2, immx, instr, isimmediate} !== '0)
            $display("FAIL reset_outputs got %0h want 0", {alusignals, op1, op2, immx, instr, isimmediate}); else n_pass++;
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_add();
        set_disp(12'h001, 16'h1000, 5'd0, 0, 16'h0010, 1, 3'd0, 16'h0005, 1, 3'd0);
        cycle(); idle();
        n_chk++; if (count !== 4'd1 || iss_valid !== 1'b0) $display("FAIL add_accept got count=%0d iss=%0b want 1/0", count, iss_valid); else n_pass++;
        cycle();
        n_chk++; if (iss_valid !== 1'b1) $display("FAIL add_iss got %0b want 1", iss_valid); else n_pass++;
        n_chk++; if (op1 !== 16'h0010 || op2 !== 16'h0005 || alusignals !== 12'h001)
            $display("FAIL add_data got %h %h %h want 0010 0005 001", op1, op2, alusignals); else n_pass++;
        n_chk++; if (count !== 4'd0) $display("FAIL add_count got %0d want 0", count); else n_pass++;
        cycle();
        n_chk++; if (iss_valid !== 1'b0 || op1 !== 16'h0010) $display("FAIL add_hold got iss=%0b op1=%h want 0/0010", iss_valid, op1); else n_pass++;
    endtask

    task automatic test_wakeup();
        set_disp(12'h002, 16'h2000, 5'd0, 0, 16'h0000, 0, 3'd3, 16'h0007, 1, 3'd0);
        cycle(); idle();
        cycle();
        n_chk++; if (iss_valid !== 1'b0) $display("FAIL wake_early got %0b want 0", iss_valid); else n_pass++;
        set_wb(3'd3, 16'h00AA);
        cycle(); idle();
        n_chk++; if (iss_valid !== 1'b0) $display("FAIL wake_same got %0b want 0", iss_valid); else n_pass++;
        cycle();
        n_chk++; if (iss_valid !== 1'b1 || op1 !== 16'h00AA || op2 !== 16'h0007 || alusignals !== 12'h002)
            $display("FAIL wake_iss got iss=%0b op1=%h op2=%h alu=%h want 1 00aa 0007 002", iss_valid, op1, op2, alusignals); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_disp(12'h004, 16'h3000 + 16'(i), 5'd0, 0, 16'h0, 0, 3'd5, 16'h0011, 1, 3'd0);
            cycle();
        end
        n_chk++; if (disp_ready !== 1'b0 || count !== 4'd4) $display("FAIL full_ready got rdy=%0b count=%0d want 0/4", disp_ready, count); else n_pass++;
        set_disp(12'h004, 16'h30FF, 5'd0, 0, 16'h0, 1, 3'd0, 16'h0, 1, 3'd0);
        cycle(); idle();
        n_chk++; if (count !== 4'd4 || iss_valid !== 1'b0) $display("FAIL full_drop got count=%0d iss=%0b want 4/0", count, iss_valid); else n_pass++;
        set_wb(3'd5, 16'h0555);
        cycle(); idle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_chk++; if (iss_valid !== 1'b1 || instr !== 16'h3000 + 16'(i) || op1 !== 16'h0555)
                $display("FAIL full_order%0d got iss=%0b instr=%h op1=%h want 1 %h 0555", i, iss_valid, instr, op1, 16'h3000 + 16'(i)); else n_pass++;
        end
        n_chk++; if (count !== 4'd0) $display("FAIL full_drain got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_out_of_order();
        set_disp(12'h008, 16'h4000, 5'd0, 0, 16'h0, 0, 3'd2, 16'h0001, 1, 3'd0);
        cycle();
        set_disp(12'h008, 16'h4001, 5'd0, 0, 16'h0101, 1, 3'd0, 16'h0001, 1, 3'd0);
        cycle();
        set_disp(12'h008, 16'h4002, 5'd0, 0, 16'h0, 0, 3'd2, 16'h0002, 1, 3'd0);
        cycle(); idle();
        n_chk++; if (iss_valid !== 1'b1 || instr !== 16'h4001 || count !== 4'd2)
            $display("FAIL ooo_first got iss=%0b instr=%h count=%0d want 1 4001 2", iss_valid, instr, count); else n_pass++;
        set_wb(3'd2, 16'h0BEE);
        cycle(); idle();
        n_chk++; if (iss_valid !== 1'b0) $display("FAIL ooo_wait got %0b want 0", iss_valid); else n_pass++;
        cycle();
        n_chk++; if (iss_valid !== 1'b1 || instr !== 16'h4000 || op1 !== 16'h0BEE)
            $display("FAIL ooo_second got iss=%0b instr=%h op1=%h want 1 4000 0bee", iss_valid, instr, op1); else n_pass++;
        cycle();
        n_chk++; if (iss_valid !== 1'b1 || instr !== 16'h4002 || op2 !== 16'h0002 || count !== 4'd0)
            $display("FAIL ooo_compact got iss=%0b instr=%h op2=%h count=%0d want 1 4002 0002 0", iss_valid, instr, op2, count); else n_pass++;
    endtask

    task automatic test_immediate_bypass();
        set_disp(12'h010, 16'h5000, 5'b00101, 1, 16'h0003, 1, 3'd0, 16'h0, 0, 3'd4);
        cycle(); idle();
        cycle();
        n_chk++; if (iss_valid !== 1'b1 || immx !== 5'h05 || isimmediate !== 1'b1 || op1 !== 16'h0003)
            $display("FAIL imm_iss got iss=%0b immx=%h isimm=%0b op1=%h want 1 05 1 0003", iss_valid, immx, isimmediate, op1); else n_pass++;
        set_disp(12'h020, 16'h5001, 5'd0, 0, 16'h0, 0, 3'd6, 16'h0009, 1, 3'd0);
        set_wb(3'd6, 16'h1234);
        cycle(); idle();
        cycle();
        n_chk++; if (iss_valid !== 1'b1 || op1 !== 16'h1234 || instr !== 16'h5001)
            $display("FAIL bypass got iss=%0b op1=%h instr=%h want 1 1234 5001", iss_valid, op1, instr); else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            set_disp(12'h040, 16'h6000 + 16'(i), 5'd0, 0, 16'h0, 0, 3'd7, 16'h0, 1, 3'd0);
            cycle();
        end
        set_disp(12'h040, 16'h60FF, 5'd0, 0, 16'h0077, 1, 3'd0, 16'h0, 1, 3'd0);
        flush = 1;
        cycle(); idle();
        n_chk++; if (count !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1)
            $display("FAIL flush_clear got count=%0d iss=%0b rdy=%0b want 0 0 1", count, iss_valid, disp_ready); else n_pass++;
        set_wb(3'd7, 16'h0777);
        cycle(); idle();
        cycle();
        n_chk++; if (iss_valid !== 1'b0 || count !== 4'd0) $display("FAIL flush_gone got iss=%0b count=%0d want 0 0", iss_valid, count); else n_pass++;
    endtask

    task automatic test_async_reset();
        set_disp(12'h080, 16'h7000, 5'd0, 0, 16'h0, 0, 3'd1, 16'h0, 1, 3'd0);
        cycle(); cycle(); idle();
        #2 rst_n = 0;
        #1;
        n_chk++; if (count !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1)
            $display("FAIL async_rst got count=%0d iss=%0b rdy=%0b want 0 0 1", count, iss_valid, disp_ready); else n_pass++;
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        set_wb(3'd1, 16'h0001);
        cycle(); idle();
        cycle();
        n_chk++; if (iss_valid !== 1'b0 || count !== 4'd0) $display("FAIL async_after got iss=%0b count=%0d want 0 0", iss_valid, count); else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            disp_valid = ($urandom_range(9) < 6);
            disp_alusignals = 12'(1 << $urandom_range(11));
            disp_instr = 16'($urandom); disp_immx = 5'($urandom);
            disp_isimmediate = ($urandom_range(4) == 0);
            disp_op1 = 16'($urandom); disp_op2 = 16'($urandom);
            disp_op1_rdy = ($urandom_range(9) < 6); disp_op2_rdy = ($urandom_range(9) < 6);
            disp_op1_tag = 3'($urandom); disp_op2_tag = 3'($urandom);
            wb_valid = ($urandom_range(9) < 4); wb_rdval = 19'($urandom);
            flush = ($urandom_range(49) == 0);
            cycle();
            n_chk++;
            if (iss_valid !== e_iss || count !== 4'(mq.size()) || disp_ready !== (mq.size() < 4) ||
                alusignals !== e_alu || op1 !== e_op1 || op2 !== e_op2 || immx !== e_immx ||
                instr !== e_instr || isimmediate !== e_isimm) begin
                if (errs < 5)
                    $display("FAIL rand_c%0d got iss=%0b cnt=%0d alu=%h op1=%h op2=%h imm=%h ins=%h isi=%0b want iss=%0b cnt=%0d alu=%h op1=%h op2=%h imm=%h ins=%h isi=%0b",
                             c, iss_valid, count, alusignals, op1, op2, immx, instr, isimmediate,
                             e_iss, mq.size(), e_alu, e_op1, e_op2, e_immx, e_instr, e_isimm);
                errs++;
            end else n_pass++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_wakeup();
        test_full();
        test_out_of_order();
        test_immediate_bypass();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
